// File: rtl/trap_seq_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET, then
// turns each accepted event into an ordered series of CSR writes plus a fetch redirect.
module trap_seq_ctrl #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_valid_i,
  input  logic                  exc_valid_i,
  input  logic [3:0]            exc_cause_i,
  input  logic [XLEN-1:0]       exc_tval_i,
  input  logic [XLEN-1:0]       wb_pc_i,
  input  logic                  mret_i,
  input  logic                  xint_meip_i,
  input  logic                  xint_mtip_i,
  input  logic                  xint_msip_i,
  input  logic [2:0]            mie_i,
  input  logic [XLEN-1:0]       mstatus_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic [XLEN-1:0]       mepc_i,
  output logic                  squash_o,
  output logic                  flush_o,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  output logic                  redirect_valid_o,
  output logic [XLEN-1:0]       redirect_pc_o,
  input  logic                  redirect_ready_i,
  output logic                  busy_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_MEPC    = 3'd1;
  localparam logic [2:0] W_MCAUSE  = 3'd2;
  localparam logic [2:0] W_MTVAL   = 3'd3;
  localparam logic [2:0] W_MSTATUS = 3'd4;
  localparam logic [2:0] R_MSTATUS = 3'd5;
  localparam logic [2:0] REDIRECT  = 3'd6;

  localparam logic [CSR_ADDR_W-1:0] ADDR_MSTATUS = CSR_ADDR_W'('h300);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC    = CSR_ADDR_W'('h341);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE  = CSR_ADDR_W'('h342);
  localparam logic [CSR_ADDR_W-1:0] ADDR_MTVAL   = CSR_ADDR_W'('h343);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [2:0]      state;
  logic [2:0]      state_d;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] target_q;

  logic            idle;
  logic [2:0]      int_pend;
  logic            int_ok;
  logic [3:0]      int_code;
  logic            take_exc;
  logic            take_int;
  logic            take_mret;
  logic            accept;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mret_target;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] int_cause;
  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] mret_mstatus;

  // Event arbitration; gating with rst_i keeps squash/flush low during reset.
  always_comb begin
    idle     = (state == IDLE);
    int_pend = {xint_meip_i & mie_i[2], xint_mtip_i & mie_i[1], xint_msip_i & mie_i[0]};
    int_ok   = mstatus_i[3] && (int_pend != 3'b000);
    if (int_pend[2]) begin
      int_code = 4'd11;
    end else if (int_pend[0]) begin
      int_code = 4'd3;
    end else begin
      int_code = 4'd7;
    end
    take_exc  = rst_i && idle && wb_valid_i && exc_valid_i;
    take_int  = rst_i && idle && wb_valid_i && !exc_valid_i && int_ok;
    take_mret = rst_i && idle && wb_valid_i && !exc_valid_i && !int_ok && mret_i;
    accept    = take_exc || take_int || take_mret;
  end

  always_comb begin
    exc_cause  = {1'b0, {(XLEN-5){1'b0}}, exc_cause_i};
    int_cause  = {1'b1, {(XLEN-5){1'b0}}, int_code};
    mtvec_base = mtvec_i & ALIGN_MASK;
    // Only interrupts use the vectored offset; exceptions always go to the base.
    if ((mtvec_i[1:0] == 2'b01) && take_int) begin
      trap_target = mtvec_base + XLEN'({int_code, 2'b00});
    end else begin
      trap_target = mtvec_base;
    end
    mret_target = mepc_i & ALIGN_MASK;
  end

  always_comb begin
    trap_mstatus        = mstatus_i;
    trap_mstatus[7]     = mstatus_i[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;

    mret_mstatus        = mstatus_i;
    mret_mstatus[3]     = mstatus_i[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (take_exc || take_int) begin
          state_d = W_MEPC;
        end else if (take_mret) begin
          state_d = R_MSTATUS;
        end
      end
      W_MEPC:    state_d = W_MCAUSE;
      W_MCAUSE:  state_d = W_MTVAL;
      W_MTVAL:   state_d = W_MSTATUS;
      W_MSTATUS: state_d = REDIRECT;
      R_MSTATUS: state_d = REDIRECT;
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cause_q  <= '0;
      tval_q   <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        epc_q <= wb_pc_i;
      end
      if (take_exc) begin
        cause_q  <= exc_cause;
        tval_q   <= exc_tval_i;
        target_q <= trap_target;
      end else if (take_int) begin
        cause_q  <= int_cause;
        tval_q   <= '0;
        target_q <= trap_target;
      end else if (take_mret) begin
        target_q <= mret_target;
      end
    end
  end

  always_comb begin
    squash_o         = take_exc || take_int;
    flush_o          = accept || !idle;
    busy_o           = !idle;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = epc_q;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      W_MTVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MTVAL;
        csr_wdata_o = tval_q;
      end
      W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = trap_mstatus;
      end
      R_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mret_mstatus;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Bench for trap_seq_ctrl: table of directed events, hand-written corner sequences,
// and a randomized run against a queue-of-expected-operations reference model.
module tb_trap_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i, exc_valid_i, mret_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_tval_i, wb_pc_i;
  logic        xint_meip_i, xint_mtip_i, xint_msip_i;
  logic [2:0]  mie_i;
  logic [31:0] mstatus_i, mtvec_i, mepc_i;
  logic        squash_o, flush_o, csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  trap_seq_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .exc_valid_i(exc_valid_i),
    .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i), .wb_pc_i(wb_pc_i), .mret_i(mret_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .mie_i(mie_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .squash_o(squash_o), .flush_o(flush_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             exc;
    logic [3:0]       cause;
    logic [31:0]      tval, pc;
    logic             mret, meip, mtip, msip;
    logic [2:0]       mie;
    logic [31:0]      mstatus, mtvec, mepc;
    logic             e_squash;
    int unsigned      e_nwr;
    logic [11:0]      e_wa [4];
    logic [31:0]      e_wd [4];
    logic [31:0]      e_pc;
  } vec_t;

  typedef struct {
    int          kind;   // 0 fixed write, 1 trap mstatus, 2 mret mstatus, 3 redirect
    logic [11:0] addr;
    logic [31:0] data;
  } step_t;

  vec_t  vecs [10];
  step_t exp_q [$];

  function automatic vec_t mk_trap(logic exc, logic [3:0] cause, logic [31:0] tval, logic [31:0] pc,
                                   logic meip, logic mtip, logic msip, logic [2:0] mie,
                                   logic [31:0] mst, logic [31:0] mtvec, logic [31:0] e_cause,
                                   logic [31:0] e_tval, logic [31:0] e_mst, logic [31:0] e_pc);
    vec_t v;
    v.exc = exc; v.cause = cause; v.tval = tval; v.pc = pc; v.mret = 1'b0;
    v.meip = meip; v.mtip = mtip; v.msip = msip; v.mie = mie;
    v.mstatus = mst; v.mtvec = mtvec; v.mepc = 32'h0;
    v.e_squash = 1'b1; v.e_nwr = 4;
    v.e_wa[0] = 12'h341; v.e_wd[0] = pc;
    v.e_wa[1] = 12'h342; v.e_wd[1] = e_cause;
    v.e_wa[2] = 12'h343; v.e_wd[2] = e_tval;
    v.e_wa[3] = 12'h300; v.e_wd[3] = e_mst;
    v.e_pc = e_pc;
    return v;
  endfunction

  function automatic vec_t mk_mret(logic [31:0] pc, logic meip, logic [2:0] mie, logic [31:0] mst,
                                   logic [31:0] mepc, logic [31:0] e_mst, logic [31:0] e_pc);
    vec_t v;
    v = mk_trap(1'b0, 4'd0, 32'h0, pc, meip, 1'b0, 1'b0, mie, mst, 32'h0, 32'h0, 32'h0, 32'h0, e_pc);
    v.mret = 1'b1; v.mepc = mepc; v.e_squash = 1'b0; v.e_nwr = 1;
    v.e_wa[0] = 12'h300; v.e_wd[0] = e_mst;
    return v;
  endfunction

  // Called at a negedge with inputs already driven; checks mid-cycle, returns at next negedge.
  task automatic check_cycle(input string name, input logic e_sq, input logic e_fl, input logic e_we,
                             input logic [11:0] e_a, input logic [31:0] e_d, input logic e_rv,
                             input logic [31:0] e_pc, input logic e_busy);
    logic ok;
    #2;
    ok = (squash_o === e_sq) && (flush_o === e_fl) && (csr_we_o === e_we) &&
         (csr_waddr_o === e_a) && (csr_wdata_o === e_d) && (redirect_valid_o === e_rv) &&
         (!e_rv || (redirect_pc_o === e_pc)) && (busy_o === e_busy);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s @%0t got sq=%b fl=%b we=%b a=%h d=%h rv=%b pc=%h busy=%b want sq=%b fl=%b we=%b a=%h d=%h rv=%b pc=%h busy=%b",
               name, $time, squash_o, flush_o, csr_we_o, csr_waddr_o, csr_wdata_o, redirect_valid_o,
               redirect_pc_o, busy_o, e_sq, e_fl, e_we, e_a, e_d, e_rv, e_pc, e_busy);
    end
    @(negedge clk_i);
  endtask

  task automatic exp_idle(input string name, input logic sq, input logic fl);
    check_cycle(name, sq, fl, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic exp_wr(input string name, input logic [11:0] a, input logic [31:0] d);
    check_cycle(name, 1'b0, 1'b1, 1'b1, a, d, 1'b0, 32'h0, 1'b1);
  endtask
  task automatic exp_rd(input string name, input logic [31:0] pc);
    check_cycle(name, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, pc, 1'b1);
  endtask

  task automatic clear_events();
    wb_valid_i = 1'b0; exc_valid_i = 1'b0; mret_i = 1'b0;
    xint_meip_i = 1'b0; xint_mtip_i = 1'b0; xint_msip_i = 1'b0;
  endtask

  task automatic drive_exc(input logic [3:0] c, input logic [31:0] tv, input logic [31:0] pc);
    wb_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = c; exc_tval_i = tv; wb_pc_i = pc;
  endtask

  function automatic logic [31:0] mst_trap(logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction
  function automatic logic [31:0] mst_mret(logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
  endfunction

  initial begin
    vecs[0] = mk_trap(1, 4'd2, 32'hDEADBEEF, 32'h100, 0, 0, 0, 3'b000, 32'h8, 32'h200,
                      32'h2, 32'hDEADBEEF, 32'h1880, 32'h200);
    vecs[1] = mk_trap(0, 4'd0, 32'h0, 32'h400, 1, 1, 0, 3'b111, 32'h8, 32'h201,
                      32'h8000000B, 32'h0, 32'h1880, 32'h22C);
    vecs[2] = mk_trap(1, 4'd5, 32'h12345678, 32'h80, 0, 0, 0, 3'b000, 32'h0, 32'h301,
                      32'h5, 32'h12345678, 32'h1800, 32'h300);
    vecs[3] = mk_trap(0, 4'd0, 32'h0, 32'h500, 0, 1, 0, 3'b010, 32'h8, 32'h1001,
                      32'h80000007, 32'h0, 32'h1880, 32'h101C);
    vecs[4] = mk_trap(0, 4'd0, 32'h0, 32'h600, 0, 1, 1, 3'b011, 32'h88, 32'h2000,
                      32'h80000003, 32'h0, 32'h1880, 32'h2000);
    vecs[5] = mk_trap(0, 4'd0, 32'h0, 32'h700, 1, 0, 0, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFF1,
                      32'h8000000B, 32'h0, 32'hFFFFFFF7, 32'h1C);
    vecs[6] = mk_mret(32'h300, 0, 3'b000, 32'h1880, 32'h104, 32'h1888, 32'h104);
    vecs[7] = mk_mret(32'h304, 0, 3'b000, 32'h8, 32'h107, 32'h1880, 32'h104);
    vecs[8] = mk_mret(32'h308, 1, 3'b100, 32'h80, 32'h200, 32'h1888, 32'h200);
    vecs[9] = mk_trap(1, 4'd3, 32'h0, 32'h900, 0, 0, 0, 3'b000, 32'h1808, 32'h40,
                      32'h3, 32'h0, 32'h1880, 32'h40);
    vecs[9].mret = 1'b1;

    rst_i = 1'b0; clear_events();
    exc_cause_i = '0; exc_tval_i = '0; wb_pc_i = '0; mie_i = '0;
    mstatus_i = '0; mtvec_i = '0; mepc_i = '0; redirect_ready_i = 1'b1;
    @(negedge clk_i);
    drive_exc(4'd1, 32'h1, 32'h10);
    exp_idle("reset", 1'b0, 1'b0);
    clear_events(); rst_i = 1'b1;
    exp_idle("post_reset", 1'b0, 1'b0);

    foreach (vecs[i]) begin
      wb_valid_i = 1'b1; exc_valid_i = vecs[i].exc; exc_cause_i = vecs[i].cause;
      exc_tval_i = vecs[i].tval; wb_pc_i = vecs[i].pc; mret_i = vecs[i].mret;
      xint_meip_i = vecs[i].meip; xint_mtip_i = vecs[i].mtip; xint_msip_i = vecs[i].msip;
      mie_i = vecs[i].mie; mstatus_i = vecs[i].mstatus; mtvec_i = vecs[i].mtvec;
      mepc_i = vecs[i].mepc; redirect_ready_i = 1'b1;
      check_cycle($sformatf("vec%0d_accept", i), vecs[i].e_squash, 1'b1, 1'b0, 12'h0, 32'h0,
                  1'b0, 32'h0, 1'b0);
      clear_events();
      for (int unsigned k = 0; k < vecs[i].e_nwr; k++)
        exp_wr($sformatf("vec%0d_wr%0d", i, k), vecs[i].e_wa[k], vecs[i].e_wd[k]);
      exp_rd($sformatf("vec%0d_redirect", i), vecs[i].e_pc);
      exp_idle($sformatf("vec%0d_idle", i), 1'b0, 1'b0);
    end

    // Interrupts masked by mstatus.MIE: nothing is accepted.
    wb_valid_i = 1'b1; xint_meip_i = 1'b1; xint_mtip_i = 1'b1; mie_i = 3'b111;
    mstatus_i = 32'h0; mtvec_i = 32'h201;
    exp_idle("mie0_a", 1'b0, 1'b0);
    exp_idle("mie0_b", 1'b0, 1'b0);
    clear_events();

    // Exception beats a simultaneous MSI; the MSI is taken once back in IDLE.
    drive_exc(4'd7, 32'hAA, 32'h10); xint_msip_i = 1'b1; mie_i = 3'b001;
    mstatus_i = 32'h8; mtvec_i = 32'h81;
    exp_idle("pri_accept", 1'b1, 1'b1);
    wb_valid_i = 1'b0; exc_valid_i = 1'b0;
    exp_wr("pri_mepc", 12'h341, 32'h10);
    exp_wr("pri_mcause", 12'h342, 32'h7);
    exp_wr("pri_mtval", 12'h343, 32'hAA);
    exp_wr("pri_mstatus", 12'h300, 32'h1880);
    wb_valid_i = 1'b1; wb_pc_i = 32'h20;
    exp_rd("pri_redirect", 32'h80);
    exp_idle("pri_int_accept", 1'b1, 1'b1);
    clear_events();
    exp_wr("pri_int_mepc", 12'h341, 32'h20);
    exp_wr("pri_int_mcause", 12'h342, 32'h80000003);
    exp_wr("pri_int_mtval", 12'h343, 32'h0);
    exp_wr("pri_int_mstatus", 12'h300, 32'h1880);
    exp_rd("pri_int_redirect", 32'h8C);
    exp_idle("pri_int_idle", 1'b0, 1'b0);

    // Redirect stall of 7 cycles with new events presented and ignored.
    redirect_ready_i = 1'b0; mstatus_i = 32'h0; mtvec_i = 32'h3000;
    drive_exc(4'd1, 32'h0, 32'h44);
    exp_idle("stall_accept", 1'b1, 1'b1);
    clear_events();
    exp_wr("stall_mepc", 12'h341, 32'h44);
    exp_wr("stall_mcause", 12'h342, 32'h1);
    exp_wr("stall_mtval", 12'h343, 32'h0);
    exp_wr("stall_mstatus", 12'h300, 32'h1800);
    drive_exc(4'd2, 32'h5, 32'h48); xint_meip_i = 1'b1; mie_i = 3'b111; mstatus_i = 32'h8;
    for (int k = 0; k < 7; k++) exp_rd($sformatf("stall_hold%0d", k), 32'h3000);
    redirect_ready_i = 1'b1;
    exp_rd("stall_release", 32'h3000);
    clear_events();
    exp_idle("stall_idle", 1'b0, 1'b0);

    // Reset in W_MTVAL aborts the sequence.
    mstatus_i = 32'h8; mtvec_i = 32'h100;
    drive_exc(4'd4, 32'h9, 32'h60);
    exp_idle("rst_accept", 1'b1, 1'b1);
    clear_events();
    exp_wr("rst_mepc", 12'h341, 32'h60);
    exp_wr("rst_mcause", 12'h342, 32'h4);
    rst_i = 1'b0;
    exp_idle("rst_abort", 1'b0, 1'b0);
    rst_i = 1'b1;
    for (int k = 0; k < 6; k++) exp_idle($sformatf("rst_after%0d", k), 1'b0, 1'b0);

    // Randomized run against the reference model.
    exp_q.delete();
    for (int n = 0; n < 4000; n++) begin
      logic [2:0]  pe;
      logic        intr, t_exc, t_int, t_mret;
      logic [3:0]  code;
      logic        e_sq, e_fl, e_we, e_rv, e_busy;
      logic [11:0] e_a;
      logic [31:0] e_d, e_pc, base;
      rst_i = ($urandom_range(0, 199) != 0);
      wb_valid_i = ($urandom_range(0, 3) != 0);
      exc_valid_i = ($urandom_range(0, 5) == 0);
      mret_i = ($urandom_range(0, 3) == 0);
      exc_cause_i = 4'($urandom_range(0, 15));
      exc_tval_i = $urandom; wb_pc_i = $urandom;
      xint_meip_i = ($urandom_range(0, 5) == 0);
      xint_mtip_i = ($urandom_range(0, 5) == 0);
      xint_msip_i = ($urandom_range(0, 5) == 0);
      mie_i = 3'($urandom_range(0, 7));
      mstatus_i = $urandom; mepc_i = $urandom;
      mtvec_i = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
      redirect_ready_i = ($urandom_range(0, 2) != 0);

      pe = {xint_meip_i & mie_i[2], xint_mtip_i & mie_i[1], xint_msip_i & mie_i[0]};
      intr = mstatus_i[3] && (pe != 3'b000);
      code = pe[2] ? 4'd11 : (pe[0] ? 4'd3 : 4'd7);
      t_exc = wb_valid_i && exc_valid_i;
      t_int = wb_valid_i && !exc_valid_i && intr;
      t_mret = wb_valid_i && !exc_valid_i && !intr && mret_i;

      e_sq = 0; e_fl = 0; e_we = 0; e_a = '0; e_d = '0; e_rv = 0; e_pc = '0; e_busy = 0;
      if (rst_i) begin
        if (exp_q.size() == 0) begin
          e_sq = t_exc || t_int;
          e_fl = t_exc || t_int || t_mret;
        end else begin
          e_fl = 1; e_busy = 1;
          case (exp_q[0].kind)
            0: begin e_we = 1; e_a = exp_q[0].addr; e_d = exp_q[0].data; end
            1: begin e_we = 1; e_a = 12'h300; e_d = mst_trap(mstatus_i); end
            2: begin e_we = 1; e_a = 12'h300; e_d = mst_mret(mstatus_i); end
            default: begin e_rv = 1; e_pc = exp_q[0].data; end
          endcase
        end
      end
      check_cycle("rand", e_sq, e_fl, e_we, e_a, e_d, e_rv, e_pc, e_busy);

      if (!rst_i) begin
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        base = mtvec_i & ~32'h3;
        if (t_exc || t_int) begin
          exp_q.push_back('{0, 12'h341, wb_pc_i});
          exp_q.push_back('{0, 12'h342, t_exc ? {28'h0, exc_cause_i} : {28'h8000000, code}});
          exp_q.push_back('{0, 12'h343, t_exc ? exc_tval_i : 32'h0});
          exp_q.push_back('{1, 12'h300, 32'h0});
          exp_q.push_back('{3, 12'h0, (t_int && mtvec_i[1:0] == 2'b01) ? base + 32'(code) * 4 : base});
        end else if (t_mret) begin
          exp_q.push_back('{2, 12'h300, 32'h0});
          exp_q.push_back('{3, 12'h0, mepc_i & ~32'h3});
        end
      end else if (exp_q[0].kind != 3 || redirect_ready_i) begin
        void'(exp_q.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
